// File: rtl/fifo2mm_writer.sv
// Moves pixel words from a first-word-fall-through FIFO into a frame buffer with fixed-length AXI4 write bursts.
// Tracks column/row position to restart at base_addr on each start-of-frame word.
module fifo2mm_writer #(
    parameter int C_IMG_WBITS        = 12,
    parameter int C_IMG_HBITS        = 12,
    parameter int C_ADATA_PIXELS     = 4,
    parameter int C_DATACOUNT_BITS   = 12,
    parameter int C_M_AXI_BURST_LEN  = 16,
    parameter int C_M_AXI_ID_WIDTH   = 1,
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32
) (
    input  logic                              M_AXI_ACLK,
    input  logic                              M_AXI_ARESETN,
    input  logic                              soft_resetn,
    output logic                              resetting,
    input  logic [C_IMG_WBITS-1:0]            img_width,
    input  logic [C_IMG_HBITS-1:0]            img_height,
    input  logic                              sof,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     din,
    input  logic                              empty,
    output logic                              rd_en,
    input  logic [C_DATACOUNT_BITS-1:0]       rd_data_count,
    output logic                              frame_pulse,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]     base_addr,
    output logic [C_M_AXI_ID_WIDTH-1:0]       M_AXI_AWID,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic [7:0]                        M_AXI_AWLEN,
    output logic [2:0]                        M_AXI_AWSIZE,
    output logic [1:0]                        M_AXI_AWBURST,
    output logic                              M_AXI_AWLOCK,
    output logic [3:0]                        M_AXI_AWCACHE,
    output logic [2:0]                        M_AXI_AWPROT,
    output logic [3:0]                        M_AXI_AWQOS,
    output logic                              M_AXI_AWVALID,
    input  logic                              M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                              M_AXI_WLAST,
    output logic                              M_AXI_WVALID,
    input  logic                              M_AXI_WREADY,
    input  logic [1:0]                        M_AXI_BRESP,
    input  logic                              M_AXI_BVALID,
    output logic                              M_AXI_BREADY
);

    localparam int LP_BEAT_W = (C_M_AXI_BURST_LEN > 1) ? $clog2(C_M_AXI_BURST_LEN) : 1;
    localparam logic [LP_BEAT_W-1:0]          LP_LAST_BEAT   = LP_BEAT_W'(C_M_AXI_BURST_LEN - 1);
    localparam logic [C_M_AXI_ADDR_WIDTH-1:0] LP_BURST_BYTES =
        C_M_AXI_ADDR_WIDTH'(C_M_AXI_BURST_LEN * (C_M_AXI_DATA_WIDTH / 8));
    localparam logic [C_DATACOUNT_BITS-1:0]   LP_BURST_CNT   = C_DATACOUNT_BITS'(C_M_AXI_BURST_LEN);
    localparam logic [C_IMG_WBITS-1:0]        LP_PIX         = C_IMG_WBITS'(C_ADATA_PIXELS);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_ADDR,
        ST_DATA,
        ST_RESP
    } state_t;

    state_t                          r_state;
    logic [C_IMG_WBITS-1:0]          r_col;
    logic [C_IMG_HBITS-1:0]          r_row;
    logic [LP_BEAT_W-1:0]            r_beat;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   r_awaddr;
    logic                            r_awvalid;
    logic                            r_bready;
    logic                            r_frame_pulse;
    logic                            r_resetting;

    logic w_at_bound;
    logic w_can_start;
    logic w_sync_start;
    logic w_burst_start;
    logic w_wvalid;
    logic w_wfire;
    logic w_unused;

    assign w_at_bound    = (r_col == '0) && (r_row == '0);
    assign w_can_start   = soft_resetn && !r_resetting && (img_width != '0) && (img_height != '0);
    assign w_sync_start  = w_can_start && w_at_bound && !empty && !sof;
    // A frame may only begin on its sof word; mid-frame bursts just need a full burst buffered.
    assign w_burst_start = w_can_start && (rd_data_count >= LP_BURST_CNT) &&
                           (!w_at_bound || (!empty && sof));
    assign w_wvalid      = (r_state == ST_DATA) && !empty;
    assign w_wfire       = w_wvalid && M_AXI_WREADY;
    assign w_unused      = ^M_AXI_BRESP;

    // The sof word itself is left in the FIFO so the frame starts on it.
    assign rd_en         = ((r_state == ST_SYNC) && !empty && !sof) || w_wfire;

    assign resetting     = r_resetting;
    assign frame_pulse   = r_frame_pulse;
    assign M_AXI_AWID    = '0;
    assign M_AXI_AWADDR  = r_awaddr;
    assign M_AXI_AWLEN   = 8'(C_M_AXI_BURST_LEN - 1);
    assign M_AXI_AWSIZE  = 3'($clog2(C_M_AXI_DATA_WIDTH / 8));
    assign M_AXI_AWBURST = 2'b01;
    assign M_AXI_AWLOCK  = 1'b0;
    assign M_AXI_AWCACHE = 4'b0000;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWQOS   = 4'b0000;
    assign M_AXI_AWVALID = r_awvalid;
    assign M_AXI_WDATA   = din;
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_WLAST   = (r_state == ST_DATA) && (r_beat == LP_LAST_BEAT);
    assign M_AXI_WVALID  = w_wvalid;
    assign M_AXI_BREADY  = r_bready;

    always_ff @(posedge M_AXI_ACLK) begin
        if (!M_AXI_ARESETN) begin
            r_state       <= ST_IDLE;
            r_col         <= '0;
            r_row         <= '0;
            r_beat        <= '0;
            r_awaddr      <= '0;
            r_awvalid     <= 1'b0;
            r_bready      <= 1'b0;
            r_frame_pulse <= 1'b0;
            r_resetting   <= 1'b1;
        end else begin
            r_frame_pulse <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (r_resetting) begin
                        r_col       <= '0;
                        r_row       <= '0;
                        r_resetting <= 1'b0;
                    end else if (w_sync_start) begin
                        r_state <= ST_SYNC;
                    end else if (w_burst_start) begin
                        r_awvalid <= 1'b1;
                        r_state   <= ST_ADDR;
                        if (w_at_bound) begin
                            r_frame_pulse <= 1'b1;
                            r_awaddr      <= base_addr;
                            r_col         <= img_width - LP_PIX;
                            r_row         <= img_height - 1'b1;
                        end else begin
                            r_awaddr <= r_awaddr + LP_BURST_BYTES;
                        end
                    end
                end
                ST_SYNC: begin
                    if (!soft_resetn || (!empty && sof)) r_state <= ST_IDLE;
                end
                ST_ADDR: begin
                    if (M_AXI_AWREADY) begin
                        r_awvalid <= 1'b0;
                        r_state   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_wfire) begin
                        // Position wraps per line and parks at 0/0 once the frame's last word is written.
                        if (r_col != '0) begin
                            r_col <= r_col - LP_PIX;
                        end else if (r_row != '0) begin
                            r_col <= img_width - LP_PIX;
                            r_row <= r_row - 1'b1;
                        end
                        if (r_beat == LP_LAST_BEAT) begin
                            r_beat   <= '0;
                            r_bready <= 1'b1;
                            r_state  <= ST_RESP;
                        end else begin
                            r_beat <= r_beat + 1'b1;
                        end
                    end
                end
                ST_RESP: begin
                    if (M_AXI_BVALID) begin
                        r_bready <= 1'b0;
                        r_state  <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
            // Soft reset is held off until the running burst has drained through its response.
            if (!soft_resetn) r_resetting <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fifo2mm_writer.sv
// Bench for fifo2mm_writer: FIFO and AXI slave models with scoreboards for AW addresses and W data.
module tb_fifo2mm_writer;

    localparam int BL = 16;

    logic        clk = 1'b0;
    logic        M_AXI_ARESETN;
    logic        soft_resetn;
    logic        resetting;
    logic [11:0] img_width;
    logic [11:0] img_height;
    logic        sof;
    logic [31:0] din;
    logic        empty;
    logic        rd_en;
    logic [11:0] rd_data_count;
    logic        frame_pulse;
    logic [31:0] base_addr;
    logic [0:0]  M_AXI_AWID;
    logic [31:0] M_AXI_AWADDR;
    logic [7:0]  M_AXI_AWLEN;
    logic [2:0]  M_AXI_AWSIZE;
    logic [1:0]  M_AXI_AWBURST;
    logic        M_AXI_AWLOCK;
    logic [3:0]  M_AXI_AWCACHE;
    logic [2:0]  M_AXI_AWPROT;
    logic [3:0]  M_AXI_AWQOS;
    logic        M_AXI_AWVALID;
    logic        M_AXI_AWREADY;
    logic [31:0] M_AXI_WDATA;
    logic [3:0]  M_AXI_WSTRB;
    logic        M_AXI_WLAST;
    logic        M_AXI_WVALID;
    logic        M_AXI_WREADY;
    logic [1:0]  M_AXI_BRESP;
    logic        M_AXI_BVALID;
    logic        M_AXI_BREADY;

    always #5 clk = ~clk;

    fifo2mm_writer dut (
        .M_AXI_ACLK(clk), .M_AXI_ARESETN(M_AXI_ARESETN), .soft_resetn(soft_resetn),
        .resetting(resetting), .img_width(img_width), .img_height(img_height),
        .sof(sof), .din(din), .empty(empty), .rd_en(rd_en), .rd_data_count(rd_data_count),
        .frame_pulse(frame_pulse), .base_addr(base_addr),
        .M_AXI_AWID(M_AXI_AWID), .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWLEN(M_AXI_AWLEN),
        .M_AXI_AWSIZE(M_AXI_AWSIZE), .M_AXI_AWBURST(M_AXI_AWBURST), .M_AXI_AWLOCK(M_AXI_AWLOCK),
        .M_AXI_AWCACHE(M_AXI_AWCACHE), .M_AXI_AWPROT(M_AXI_AWPROT), .M_AXI_AWQOS(M_AXI_AWQOS),
        .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WLAST(M_AXI_WLAST),
        .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
        .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY)
    );

    typedef struct { logic sof; logic [31:0] data; } word_t;
    typedef struct {
        logic [11:0] w;
        logic [11:0] h;
        logic [31:0] base;
        int          exp_bursts;
        int          exp_beats;
        logic [31:0] exp_last_aw;
    } frame_t;

    word_t       fifo_q[$];
    logic [31:0] exp_w[$];
    logic [31:0] exp_aw[$];

    int n_checks = 0;
    int n_errors = 0;
    int aw_cnt = 0, w_beats = 0, b_cnt = 0, pops = 0, pulses = 0, viol = 0;
    int beat_idx = 0;
    int wready_hold = 0;
    bit force_empty = 1'b0;
    logic [31:0] last_aw = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic update_ports();
        empty         = force_empty || (fifo_q.size() == 0);
        rd_data_count = 12'(fifo_q.size());
        if (fifo_q.size() > 0) begin
            din = fifo_q[0].data;
            sof = fifo_q[0].sof;
        end else begin
            din = '0;
            sof = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input int n, input int n_expect, input bit with_sof);
        word_t wd;
        for (int j = 0; j < n; j++) begin
            wd.sof  = with_sof && (j == 0);
            wd.data = $urandom;
            fifo_q.push_back(wd);
            if (j < n_expect) exp_w.push_back(wd.data);
        end
        update_ports();
    endtask

    task automatic wait_b(input int target, input int budget, input string name);
        int c = 0;
        while (b_cnt < target && c < budget) begin
            tick();
            c++;
        end
        check({name, "_bresp_timeout"}, 64'(b_cnt >= target), 64'd1);
    endtask

    task automatic wait_beats(input int target, input int budget, input string name);
        int c = 0;
        while (w_beats < target && c < budget) begin
            tick();
            c++;
        end
        check({name, "_beat_timeout"}, 64'(w_beats >= target), 64'd1);
    endtask

    // FIFO + AXI slave model: sample handshakes mid-cycle, act just after the next rising edge.
    initial begin : model
        logic pop_now, aw_hs, w_hs, b_hs;
        bit b_pending, stall_prev;
        logic [31:0] stall_data;
        b_pending = 1'b0;
        stall_prev = 1'b0;
        stall_data = '0;
        forever begin
            @(negedge clk);
            pop_now = (rd_en === 1'b1);
            aw_hs = (M_AXI_AWVALID === 1'b1) && M_AXI_AWREADY;
            w_hs  = (M_AXI_WVALID === 1'b1) && M_AXI_WREADY;
            b_hs  = (M_AXI_BREADY === 1'b1) && M_AXI_BVALID;
            if (frame_pulse === 1'b1) pulses++;
            if (pop_now && empty) viol++;
            if (M_AXI_WVALID === 1'b1) begin
                if (rd_en !== M_AXI_WREADY) viol++;
                if (stall_prev) check("wdata_stable", M_AXI_WDATA, stall_data);
                stall_prev = !M_AXI_WREADY;
                stall_data = M_AXI_WDATA;
            end
            if (aw_hs) begin
                aw_cnt++;
                last_aw = M_AXI_AWADDR;
                if (exp_aw.size() == 0) check("aw_unexpected", 64'd1, 64'd0);
                else check("awaddr", M_AXI_AWADDR, exp_aw.pop_front());
            end
            if (w_hs) begin
                w_beats++;
                if (exp_w.size() == 0) check("w_unexpected", 64'd1, 64'd0);
                else check("wdata", M_AXI_WDATA, exp_w.pop_front());
                check("wlast", 64'(M_AXI_WLAST), 64'(beat_idx == BL - 1));
                beat_idx = (beat_idx + 1) % BL;
                if (M_AXI_WLAST) b_pending = 1'b1;
            end
            if (b_hs) b_cnt++;
            @(posedge clk);
            #1;
            if (pop_now) begin
                pops++;
                if (fifo_q.size() > 0) void'(fifo_q.pop_front());
                else viol++;
            end
            if (b_hs) M_AXI_BVALID = 1'b0;
            if (b_pending) begin
                M_AXI_BVALID = 1'b1;
                b_pending = 1'b0;
            end
            if (wready_hold > 0) begin
                M_AXI_WREADY = 1'b0;
                wready_hold--;
            end else begin
                M_AXI_WREADY = 1'b1;
            end
            update_ports();
        end
    end

    initial begin : main
        frame_t tbl[4];
        int p0, a0, w0, b0, q0, snap;
        tbl[0] = '{12'd16, 12'd8,  32'h1000_0000, 2, 32, 32'h1000_0040};
        tbl[1] = '{12'd16, 12'd8,  32'h1000_0000, 2, 32, 32'h1000_0040};
        tbl[2] = '{12'd64, 12'd4,  32'h2000_0000, 4, 64, 32'h2000_00C0};
        tbl[3] = '{12'd4,  12'd16, 32'h3000_0100, 1, 16, 32'h3000_0100};

        M_AXI_ARESETN = 1'b0;
        soft_resetn   = 1'b1;
        img_width     = '0;
        img_height    = '0;
        base_addr     = '0;
        M_AXI_AWREADY = 1'b1;
        M_AXI_WREADY  = 1'b1;
        M_AXI_BVALID  = 1'b0;
        M_AXI_BRESP   = 2'b00;
        update_ports();

        repeat (3) tick();
        check("rst_awvalid", 64'(M_AXI_AWVALID), 64'd0);
        check("rst_wvalid", 64'(M_AXI_WVALID), 64'd0);
        check("rst_bready", 64'(M_AXI_BREADY), 64'd0);
        check("rst_rd_en", 64'(rd_en), 64'd0);
        check("rst_frame_pulse", 64'(frame_pulse), 64'd0);
        check("rst_awaddr", 64'(M_AXI_AWADDR), 64'd0);
        check("rst_resetting", 64'(resetting), 64'd1);
        check("awlen", 64'(M_AXI_AWLEN), 64'd15);
        check("awsize", 64'(M_AXI_AWSIZE), 64'd2);
        check("awburst", 64'(M_AXI_AWBURST), 64'd1);
        check("wstrb", 64'(M_AXI_WSTRB), 64'hF);
        check("aw_misc_zero", 64'({M_AXI_AWID, M_AXI_AWLOCK, M_AXI_AWCACHE, M_AXI_AWPROT, M_AXI_AWQOS}), 64'd0);

        M_AXI_ARESETN = 1'b1;
        tick();
        check("resetting_clears", 64'(resetting), 64'd0);

        for (int i = 0; i < 4; i++) begin
            img_width  = tbl[i].w;
            img_height = tbl[i].h;
            base_addr  = tbl[i].base;
            p0 = pulses; a0 = aw_cnt; w0 = w_beats; b0 = b_cnt;
            for (int k = 0; k < tbl[i].exp_bursts; k++) exp_aw.push_back(tbl[i].base + 32'(k * 64));
            push_frame(tbl[i].exp_beats, tbl[i].exp_beats, 1'b1);
            wait_b(b0 + tbl[i].exp_bursts, 600, "frame");
            repeat (3) tick();
            check("frame_pulses", 64'(pulses - p0), 64'd1);
            check("frame_aw_count", 64'(aw_cnt - a0), 64'(tbl[i].exp_bursts));
            check("frame_beats", 64'(w_beats - w0), 64'(tbl[i].exp_beats));
            check("frame_last_aw", 64'(last_aw), 64'(tbl[i].exp_last_aw));
            check("frame_fifo_left", 64'(fifo_q.size()), 64'd0);
        end

        // Leading non-sof words are discarded before the frame locks on.
        img_width = 12'd16; img_height = 12'd8; base_addr = 32'h1000_0000;
        p0 = pulses; a0 = aw_cnt; q0 = pops; b0 = b_cnt;
        push_frame(3, 0, 1'b0);
        repeat (10) tick();
        check("sync_pops", 64'(pops - q0), 64'd3);
        check("sync_no_aw", 64'(aw_cnt - a0), 64'd0);
        check("sync_fifo_empty", 64'(fifo_q.size()), 64'd0);
        check("sync_no_pulse", 64'(pulses - p0), 64'd0);
        exp_aw.push_back(32'h1000_0000);
        exp_aw.push_back(32'h1000_0040);
        push_frame(32, 32, 1'b1);
        wait_b(b0 + 2, 400, "sync_frame");
        repeat (3) tick();
        check("sync_frame_pulse", 64'(pulses - p0), 64'd1);
        check("sync_frame_pops", 64'(pops - q0), 64'd35);

        // WREADY stall and FIFO underrun mid-burst.
        base_addr = 32'h4000_0000;
        p0 = pulses; w0 = w_beats; b0 = b_cnt;
        exp_aw.push_back(32'h4000_0000);
        exp_aw.push_back(32'h4000_0040);
        push_frame(32, 32, 1'b1);
        wait_beats(w0 + 5, 100, "stall");
        wready_hold = 5;
        tick();
        snap = w_beats;
        repeat (3) tick();
        check("stall_no_beats", 64'(w_beats), 64'(snap));
        repeat (4) tick();
        force_empty = 1'b1;
        update_ports();
        snap = w_beats;
        repeat (3) tick();
        check("empty_no_beats", 64'(w_beats), 64'(snap));
        force_empty = 1'b0;
        update_ports();
        wait_b(b0 + 2, 400, "stall_frame");
        repeat (3) tick();
        check("stall_total_beats", 64'(w_beats - w0), 64'd32);
        check("stall_pulse", 64'(pulses - p0), 64'd1);

        // Soft reset dropped mid-burst: the burst drains, then the writer stays parked.
        base_addr = 32'h5000_0000;
        p0 = pulses; a0 = aw_cnt; w0 = w_beats; b0 = b_cnt;
        exp_aw.push_back(32'h5000_0000);
        push_frame(32, 16, 1'b1);
        wait_beats(w0 + 4, 100, "softrst");
        soft_resetn = 1'b0;
        repeat (2) tick();
        check("sr_resetting_set", 64'(resetting), 64'd1);
        wait_b(b0 + 1, 200, "softrst");
        repeat (20) tick();
        check("sr_aw_count", 64'(aw_cnt - a0), 64'd1);
        check("sr_beats", 64'(w_beats - w0), 64'd16);
        check("sr_resetting_held", 64'(resetting), 64'd1);
        check("sr_fifo_left", 64'(fifo_q.size()), 64'd16);
        check("sr_idle_wvalid", 64'(M_AXI_WVALID), 64'd0);
        soft_resetn = 1'b1;
        repeat (40) tick();
        check("sr_resetting_clear", 64'(resetting), 64'd0);
        check("sr_remainder_flushed", 64'(fifo_q.size()), 64'd0);
        check("sr_no_new_aw", 64'(aw_cnt - a0), 64'd1);

        base_addr = 32'h1000_0000;
        b0 = b_cnt;
        exp_aw.push_back(32'h1000_0000);
        exp_aw.push_back(32'h1000_0040);
        push_frame(32, 32, 1'b1);
        wait_b(b0 + 2, 400, "recover");
        repeat (3) tick();
        check("recover_pulses", 64'(pulses - p0), 64'd2);
        check("recover_last_aw", 64'(last_aw), 64'h1000_0040);

        check("protocol_violations", 64'(viol), 64'd0);
        check("exp_w_drained", 64'(exp_w.size()), 64'd0);
        check("exp_aw_drained", 64'(exp_aw.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fifo2mm_writer.md
FIFO2MM_WRITER -- requirements
Module: fifo2mm_writer

Interface
REQ-001 SHALL have parameter C_IMG_WBITS, default 12, image width field bits.
REQ-002 SHALL have parameter C_IMG_HBITS, default 12, image height field bits.
REQ-003 SHALL have parameter C_ADATA_PIXELS, default 4, pixels per data word.
REQ-004 SHALL have parameter C_DATACOUNT_BITS, default 12, FIFO count width.
REQ-005 SHALL have parameter C_M_AXI_BURST_LEN, default 16, beats per burst (1..256, power of 2).
REQ-006 SHALL have parameter C_M_AXI_ID_WIDTH, default 1, AXI ID width.
REQ-007 SHALL have parameter C_M_AXI_ADDR_WIDTH, default 32, address width.
REQ-008 SHALL have parameter C_M_AXI_DATA_WIDTH, default 32, data width.
REQ-009 SHALL have M_AXI_ACLK  in  1  the single clock; all logic on its rising edge.
REQ-010 SHALL have M_AXI_ARESETN  in  1  reset, synchronous, active-low.
REQ-011 SHALL have soft_resetn  in  1  active-low soft reset / enable.
REQ-012 SHALL have resetting  out  1  soft reset in progress.
REQ-013 SHALL have img_width  in  C_IMG_WBITS  pixels per line (multiple of C_ADATA_PIXELS).
REQ-014 SHALL have img_height  in  C_IMG_HBITS  lines per frame.
REQ-015 SHALL have sof  in  1  start-of-frame flag of FIFO head word.
REQ-016 SHALL have din  in  C_M_AXI_DATA_WIDTH  FIFO head word (first-word-fall-through).
REQ-017 SHALL have empty  in  1  FIFO empty.
REQ-018 SHALL have rd_en  out  1  FIFO pop.
REQ-019 SHALL have rd_data_count  in  C_DATACOUNT_BITS  FIFO occupancy.
REQ-020 SHALL have frame_pulse  out  1  one-cycle pulse at frame start.
REQ-021 SHALL have base_addr  in  C_M_AXI_ADDR_WIDTH  frame buffer address.
REQ-022 SHALL have M_AXI_AWADDR  out  C_M_AXI_ADDR_WIDTH  burst address.
REQ-023 SHALL have M_AXI_AWID/AWLOCK/AWCACHE/AWPROT/AWQOS  out  std widths  constant 0.
REQ-024 SHALL have M_AXI_AWLEN/AWSIZE/AWBURST  out  8/3/2  constant BURST_LEN-1, clog2(DATA_WIDTH/8), INCR.
REQ-025 SHALL have M_AXI_AWVALID out 1, M_AXI_AWREADY in 1.
REQ-026 SHALL have M_AXI_WDATA out DATA_WIDTH, M_AXI_WSTRB out DATA_WIDTH/8 (all ones), M_AXI_WLAST out 1.
REQ-027 SHALL have M_AXI_WVALID out 1, M_AXI_WREADY in 1.
REQ-028 SHALL have M_AXI_BRESP in 2, M_AXI_BVALID in 1, M_AXI_BREADY out 1.

Function
REQ-029 SHALL implement states IDLE, SYNC, ADDR, DATA, RESP.
REQ-030 SHALL track col/row counters; frame boundary = both zero.
REQ-031 IDLE->SYNC SHALL occur at frame boundary when soft_resetn, ~resetting, dims nonzero, ~empty, and head sof=0; SYNC pops (rd_en=~empty), no AXI traffic, returns to IDLE when head sof=1.
REQ-032 IDLE->ADDR SHALL occur when soft_resetn, ~resetting, dims nonzero, rd_data_count >= BURST_LEN, and (not at boundary, or head sof=1).
REQ-033 At boundary start SHALL: pulse frame_pulse one cycle, set AWADDR=base_addr, col=img_width-C_ADATA_PIXELS, row=img_height-1; else AWADDR += BURST_LEN*DATA_WIDTH/8.
REQ-034 AWVALID SHALL be 1 in ADDR, held until AWREADY; then DATA.
REQ-035 In DATA: WVALID=~empty, WDATA=din, rd_en=WVALID&WREADY, WLAST on beat BURST_LEN-1; after last beat -> RESP.
REQ-036 Each W beat SHALL decrement col by C_ADATA_PIXELS, wrapping to img_width-C_ADATA_PIXELS with row-1; at 0/0 holds.
REQ-037 RESP: BREADY=1; BVALID -> IDLE; BRESP ignored.
REQ-038 rd_en SHALL be 0 outside SYNC and DATA; head sof mid-frame ignored (data written).
REQ-039 Falling soft_resetn SHALL set resetting; active burst completes (all beats, B); then counters clear, resetting=0 in IDLE.

Reset
REQ-040 On M_AXI_ARESETN=0: state IDLE, AWVALID/WVALID/BREADY/rd_en/frame_pulse=0, AWADDR=0, counters 0, resetting=1 (clears first idle cycle).

Verification
REQ-041 width 16, height 8, base 0x10000000, FIFO 32 words sof on first -> AWADDR 0x10000000 then 0x10000040, 32 beats, WLAST beats 16/32, one frame_pulse.
REQ-042 Second frame same setup -> AWADDR returns to 0x10000000, second frame_pulse.
REQ-043 FIFO head 3 words sof=0 then sof word -> 3 pops, no AW, then frame starts at sof word.
REQ-044 WREADY low 5 cycles mid-burst, empty pulses -> no pop, WDATA stable, beat count exact.
REQ-045 soft_resetn low during DATA beat 4 -> burst finishes 16 beats + B, resetting high until IDLE, no new AW until soft_resetn=1.
